// File: rtl/fpu_addsub_seq.sv
// -----------------------------------------------------------------------------
// fpu_addsub_seq -- multi-cycle floating-point adder/subtractor
//
// Adds or subtracts two {sign, exponent, fraction} operands with a hidden
// leading one. Exponent 0 encodes zero and exponent all-ones encodes infinity;
// the fraction is ignored in both cases. Subnormals are not supported.
// The result is rounded to nearest, ties to even. Each operation walks
// IDLE -> ALIGN -> ADD -> NORM -> ROUND. Alignment and normalisation shift
// one bit per cycle, so the latency depends on the data.
//
// Parameters
//   EXP_W : exponent field width (bias = 2^(EXP_W-1)-1)
//   MAN_W : stored fraction width
//
// Ports (W = 1+EXP_W+MAN_W)
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   calc       in   start request, sampled only while idle
//   op_sub_in  in   0: A+B, 1: A-B
//   op_A_in    in   [W]  operand A
//   op_B_in    in   [W]  operand B
//   data_out   out  [W]  result, held until the next completion
//   state_out  out  State_e status, held together with data_out
//   busy       out  high from the capture edge until the completion edge
//   done       out  one-cycle completion pulse
// -----------------------------------------------------------------------------
package States;
    typedef enum logic [1:0] {
        EXACT     = 2'd0,
        INEXACT   = 2'd1,
        OVERFLOW  = 2'd2,
        UNDERFLOW = 2'd3
    } State_e;
endpackage

module fpu_addsub_seq
    import States::*;
#(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     calc,
    input  logic                     op_sub_in,
    input  logic [1+EXP_W+MAN_W-1:0] op_A_in,
    input  logic [1+EXP_W+MAN_W-1:0] op_B_in,
    output logic [1+EXP_W+MAN_W-1:0] data_out,
    output State_e                   state_out,
    output logic                     busy,
    output logic                     done
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XW = MAN_W + 4;                // hidden 1 + fraction + guard/round/sticky
    localparam int SW = MAN_W + 5;                // XW plus a carry bit
    localparam int CW = $clog2(MAN_W + 4);        // holds shift counts up to MAN_W+3
    localparam int EW = EXP_W + $clog2(MAN_W + 4) + 2; // two's-complement working exponent

    localparam logic [31:0]      DMAX      = 32'(MAN_W + 3);
    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [EW-1:0]    EXP_MAX_E = EW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4
    } fsm_e;

    fsm_e            fsm_q;
    logic [W-1:0]    a_q, b_q;            // b_q carries the already-inverted sign for A-B
    logic [XW-1:0]   big_q, small_q;
    logic            sign_big_q, sign_small_q;
    logic [EW-1:0]   exp_q;
    logic [CW-1:0]   cnt_q;
    logic [SW-1:0]   sum_q;
    logic            res_sign_q;
    logic            zero_sign_q;
    logic            ordered_q;           // first ALIGN cycle orders, the rest shift
    logic            force_inf_q;
    logic [W-1:0]    data_q;
    State_e          status_q;
    logic            busy_q, done_q;

    logic [EXP_W-1:0] a_exp, b_exp, exp_diff, big_exp_d;
    logic             a_zero, b_zero, a_ge_b;
    logic [W-2:0]     mag_a, mag_b;
    logic [XW-1:0]    ext_a, ext_b;
    logic [CW-1:0]    shift_d;
    logic [SW-1:0]    sum_d;
    logic             rnd_up;
    logic [MAN_W+1:0] man_d;
    logic [EW-1:0]    exp_rnd_d;
    logic [MAN_W-1:0] frac_rnd_d;
    logic             inexact_d, ovf_d, unf_d;

    always_comb begin
        a_exp  = a_q[W-2:MAN_W];
        b_exp  = b_q[W-2:MAN_W];
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        // Zero operands compare as magnitude 0 regardless of their fraction.
        mag_a  = a_zero ? '0 : a_q[W-2:0];
        mag_b  = b_zero ? '0 : b_q[W-2:0];
        a_ge_b = (mag_a >= mag_b);
        ext_a  = a_zero ? '0 : {1'b1, a_q[MAN_W-1:0], 3'b000};
        ext_b  = b_zero ? '0 : {1'b1, b_q[MAN_W-1:0], 3'b000};

        if (a_ge_b) begin
            exp_diff  = a_exp - b_exp;
            big_exp_d = a_exp;
        end else begin
            exp_diff  = b_exp - a_exp;
            big_exp_d = b_exp;
        end
        // Beyond MAN_W+3 shifts every bit already sits in sticky.
        if (32'(exp_diff) > DMAX) shift_d = CW'(DMAX);
        else                      shift_d = CW'(exp_diff);

        // The ordered operands guarantee big_q >= small_q, so no borrow.
        if (sign_big_q == sign_small_q) sum_d = {1'b0, big_q} + {1'b0, small_q};
        else                            sum_d = {1'b0, big_q} - {1'b0, small_q};

        // Round to nearest even on guard/round/sticky of the normalised sum.
        rnd_up     = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
        man_d      = {1'b0, sum_q[SW-2:3]} + (MAN_W+2)'(rnd_up);
        exp_rnd_d  = man_d[MAN_W+1] ? exp_q + EW'(1) : exp_q;
        frac_rnd_d = man_d[MAN_W+1] ? man_d[MAN_W:1] : man_d[MAN_W-1:0];
        inexact_d  = |sum_q[2:0];
        ovf_d      = !exp_rnd_d[EW-1] && (exp_rnd_d >= EXP_MAX_E);
        unf_d      = exp_rnd_d[EW-1] || (exp_rnd_d == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q        <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            big_q        <= '0;
            small_q      <= '0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            exp_q        <= '0;
            cnt_q        <= '0;
            sum_q        <= '0;
            res_sign_q   <= 1'b0;
            zero_sign_q  <= 1'b0;
            ordered_q    <= 1'b0;
            force_inf_q  <= 1'b0;
            data_q       <= '0;
            status_q     <= EXACT;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (calc) begin
                        a_q       <= op_A_in;
                        b_q       <= {op_B_in[W-1] ^ op_sub_in, op_B_in[W-2:0]};
                        busy_q    <= 1'b1;
                        ordered_q <= 1'b0;
                        if (op_A_in[W-2:MAN_W] == EXP_ONES) begin
                            force_inf_q <= 1'b1;
                            res_sign_q  <= op_A_in[W-1];
                            fsm_q       <= ROUND;
                        end else if (op_B_in[W-2:MAN_W] == EXP_ONES) begin
                            force_inf_q <= 1'b1;
                            res_sign_q  <= op_B_in[W-1] ^ op_sub_in;
                            fsm_q       <= ROUND;
                        end else begin
                            force_inf_q <= 1'b0;
                            fsm_q       <= ALIGN;
                        end
                    end
                end

                ALIGN: begin
                    if (!ordered_q) begin
                        ordered_q <= 1'b1;
                        exp_q     <= EW'(big_exp_d);
                        cnt_q     <= shift_d;
                        if (a_ge_b) begin
                            big_q        <= ext_a;
                            small_q      <= ext_b;
                            sign_big_q   <= a_q[W-1];
                            sign_small_q <= b_q[W-1];
                        end else begin
                            big_q        <= ext_b;
                            small_q      <= ext_a;
                            sign_big_q   <= b_q[W-1];
                            sign_small_q <= a_q[W-1];
                        end
                        if (shift_d == '0) fsm_q <= ADD;
                    end else begin
                        // Bit 0 is sticky: it absorbs whatever falls out of bit 1.
                        small_q <= {1'b0, small_q[XW-1:2], small_q[1] | small_q[0]};
                        cnt_q   <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) fsm_q <= ADD;
                    end
                end

                ADD: begin
                    sum_q       <= sum_d;
                    res_sign_q  <= sign_big_q;
                    zero_sign_q <= sign_big_q & sign_small_q;
                    if ((sum_d != '0) && (sum_d[SW-1] || !sum_d[SW-2])) fsm_q <= NORM;
                    else                                                 fsm_q <= ROUND;
                end

                NORM: begin
                    if (sum_q[SW-1]) begin
                        sum_q <= {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
                        exp_q <= exp_q + EW'(1);
                        fsm_q <= ROUND;
                    end else begin
                        sum_q <= {sum_q[SW-2:0], 1'b0};
                        exp_q <= exp_q - EW'(1);
                        if (sum_q[SW-3]) fsm_q <= ROUND;
                    end
                end

                ROUND: begin
                    fsm_q  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    if (force_inf_q) begin
                        data_q   <= {res_sign_q, EXP_ONES, {MAN_W{1'b0}}};
                        status_q <= OVERFLOW;
                    end else if (sum_q == '0) begin
                        data_q   <= {zero_sign_q, {(W-1){1'b0}}};
                        status_q <= EXACT;
                    end else if (ovf_d) begin
                        data_q   <= {res_sign_q, EXP_ONES, {MAN_W{1'b0}}};
                        status_q <= OVERFLOW;
                    end else if (unf_d) begin
                        data_q   <= {res_sign_q, {(W-1){1'b0}}};
                        status_q <= UNDERFLOW;
                    end else begin
                        data_q   <= {res_sign_q, exp_rnd_d[EXP_W-1:0], frac_rnd_d};
                        status_q <= inexact_d ? INEXACT : EXACT;
                    end
                end

                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign data_out  = data_q;
    assign state_out = status_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/fpu_addsub_seq.md
# fpu_addsub_seq

Parametrised multi-cycle floating-point adder/subtractor; next generation of the team's 32-bit FPU. Exponent and mantissa widths are configurable, and an explicit subtract mode is added. A start/busy/done handshake exposes the variable latency. Rounding is round-to-nearest-even and a status is reported per result. It sits between the operand registers and the result bus, and reports status through the shared `States` package (`State_e`).

## Interface
- `EXP_W`, default 6: exponent field width; bias = 2^(EXP_W-1)-1 (31 by default).
- `MAN_W`, default 25: stored fraction width, hidden leading 1. Word width W = 1+EXP_W+MAN_W (32 by default).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `calc` in 1: start request, level, sampled only in IDLE.
- `op_sub_in` in 1: 0 = A+B, 1 = A-B (B sign inverted at capture).
- `op_A_in` in W: operand A, format {sign, exponent, fraction}.
- `op_B_in` in W: operand B.
- `data_out` out W: result, held until the next completion.
- `state_out` out `State_e`: EXACT, INEXACT, OVERFLOW or UNDERFLOW; held with `data_out`.
- `busy` out 1: high from the capture edge until the edge that asserts `done`.
- `done` out 1: one-cycle pulse; `data_out`/`state_out` are valid from this cycle onward.

## Operation
- Encoding: exponent 0 = zero, fraction ignored, no subnormals. Exponent all-ones = infinity, fraction ignored.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE.
- IDLE:
  - On `calc`=1, capture the operands and `op_sub_in`, assert `busy`, enter ALIGN.
  - If either operand is infinity, go directly to ROUND with a forced result: all-ones exponent, fraction 0, sign of A if A is infinite, else sign of B after the sub inversion. Status is OVERFLOW.
- ALIGN:
  - Order the operands by magnitude.
  - Shift the smaller mantissa right by 1 bit per cycle, d = min(|eA-eB|, MAN_W+3) cycles total.
  - Keep guard, round and sticky bits; sticky ORs every bit shifted past it.
  - A zero operand is handled as magnitude 0.
- ADD: one cycle. Add the mantissas if the effective signs are equal, otherwise subtract smaller from larger. Result sign = sign of the larger magnitude.
- NORM:
  - On carry-out, one right shift, exponent +1.
  - Otherwise, 1-bit left shift per cycle, exponent -1, until the MSB is 1.
  - An all-zero sum skips NORM.
  - n = number of NORM shift cycles.
- ROUND: one cycle.
  - Round to nearest even on guard/round/sticky; a mantissa carry from rounding increments the exponent.
  - Status priority, highest first:
    - OVERFLOW: exponent >= 2^EXP_W-1. Result is {sign, all-ones, 0}.
    - UNDERFLOW: exponent <= 0 with a nonzero mantissa. Result is {sign, 0, 0}.
    - INEXACT: any of guard/round/sticky is nonzero.
    - EXACT: otherwise.
  - An exact zero sum gives +0, except (-0)+(-0) gives -0.

## Timing
- Reset values: `data_out`=0, `state_out`=EXACT, `busy`=0, `done`=0, FSM = IDLE.
- Latency from the capture edge to the edge asserting `done` is 3+d+n cycles.
  - Upper bound: 3+2*(MAN_W+3).
  - Infinity path: 1 cycle.
- `done` is high for exactly one cycle; `busy` falls on the same edge.
- A new capture is possible on the edge after `done` (back-to-back throughput = latency+1).
- `calc` and operand changes while `busy`=1 are ignored; captured values are used.
- `reset` mid-operation aborts immediately. Outputs return to their reset values and no `done` is produced for the aborted operation.

## Test plan
- 1.5+2.5 (A=0_011111_1000..., B=0_100000_0100..., sub=0): `data_out`=0_100001_0...0 (4.0), EXACT, `done` 5 cycles after capture (d=1, n=1).
- 4.0 minus 2.0 via `op_sub_in`=1 (B=0_100000_0...0): `data_out`=0_100000_0...0, EXACT, latency 5. The same pair with B=-2.0 and sub=0 gives an identical result.
- Tie rounding: 1.0 + 2^-26 (B=0_000101_0...0): `data_out`=0_011111_0...0, INEXACT, latency 3+26.
- Overflow: 0_111110_1...1 + same gives {0,111111,0}, OVERFLOW. Underflow: 0_000001_0...01 - 0_000001_0...0 gives 32'h0, UNDERFLOW.
- Cancellation: 4.0 + (-4.0) gives 32'h0, EXACT. Infinity: A=0_111111_x + 1.0 gives {0,111111,0}, OVERFLOW, latency 1.
- Robustness:
  - Assert `reset` 2 cycles into the 1.0 + 2^-26 operation: all outputs return to their reset values and no `done` appears.
  - Toggling `calc` while `busy` does not alter the result.
  - EXP_W=8, MAN_W=23 rerun of the 1.5+2.5 case gives 32'h40800000.
